// File: rtl/umi_mem_checker.sv
// UMI host-side memory self-test initiator.
// Writes a seeded incrementing pattern to nwords DW-wide words, reads them back,
// compares, and reports pass/fail, error count, first failing address and timeout.
// One transaction is outstanding at a time.
module umi_mem_checker #(
    parameter int unsigned   CW       = 32,
    parameter int unsigned   AW       = 64,
    parameter int unsigned   DW       = 256,
    parameter logic [AW-1:0] BASEADDR = '0,
    parameter logic [AW-1:0] SRCADDR  = '0,
    parameter int unsigned   TIMEOUT  = 1024
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          start,
    input  logic [31:0]   seed,
    input  logic [15:0]   nwords,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [15:0]   err_count,
    output logic [AW-1:0] err_addr,
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready
);

    localparam int unsigned NLANE = DW / 32;
    localparam int unsigned BYTES = DW / 8;
    localparam int unsigned SIZE  = $clog2(BYTES);
    localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [4:0] OP_READ       = 5'h01;
    localparam logic [4:0] OP_WRITE      = 5'h03;
    localparam logic [4:0] OP_RESP_READ  = 5'h02;
    localparam logic [4:0] OP_RESP_WRITE = 5'h04;

    // cmd layout: [15:8] len=0, [7:5] size, [4:0] opcode
    localparam logic [CW-1:0] CMD_READ  = CW'({8'h00, 3'(SIZE), OP_READ});
    localparam logic [CW-1:0] CMD_WRITE = CW'({8'h00, 3'(SIZE), OP_WRITE});

    typedef enum logic [2:0] {
        S_IDLE,
        S_WREQ,
        S_WRESP,
        S_RREQ,
        S_RRESP,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [31:0]   r_seed;
    logic [15:0]   r_nwords;
    logic [15:0]   r_k;
    logic [31:0]   r_pat;
    logic [TW-1:0] r_wait;

    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic          r_timeout;
    logic [15:0]   r_err_count;
    logic [AW-1:0] r_err_addr;
    logic          r_req_valid;
    logic [CW-1:0] r_req_cmd;
    logic [AW-1:0] r_req_dstaddr;
    logic [AW-1:0] r_req_srcaddr;
    logic [DW-1:0] r_req_data;
    logic          r_resp_ready;

    logic          w_req_hs;
    logic          w_resp_hs;
    logic          w_last;
    logic          w_wait_exp;
    logic [31:0]   w_pat_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic [DW-1:0] w_exp_data;
    logic [4:0]    w_resp_op;
    logic          w_resp_err;
    logic          w_err_inc;
    logic [15:0]   w_err_count_nxt;
    logic          w_unused;

    assign w_req_hs   = r_req_valid & uhost_req_ready;
    assign w_resp_hs  = r_resp_ready & uhost_resp_valid;
    assign w_last     = (r_k == (r_nwords - 16'd1));
    assign w_wait_exp = !w_resp_hs && (r_wait == TW'(TIMEOUT - 1));
    assign w_pat_nxt  = r_pat + 32'd1;
    assign w_addr_nxt = r_req_dstaddr + AW'(BYTES);
    assign w_exp_data = {NLANE{r_pat}};
    assign w_resp_op  = uhost_resp_cmd[4:0];

    // Response check: write responses only need the right opcode, reads also compare data
    always_comb begin
        w_resp_err = 1'b0;
        if (r_state == S_WRESP) begin
            w_resp_err = (w_resp_op != OP_RESP_WRITE);
        end else if (r_state == S_RRESP) begin
            w_resp_err = (w_resp_op != OP_RESP_READ) || (uhost_resp_data != w_exp_data);
        end
    end

    assign w_err_inc       = w_resp_hs & w_resp_err;
    assign w_err_count_nxt = (w_err_inc && (r_err_count != 16'hFFFF)) ?
                             (r_err_count + 16'd1) : r_err_count;

    // Response address fields and upper cmd bits carry nothing this checker needs
    assign w_unused = ^{uhost_resp_cmd[CW-1:5], uhost_resp_dstaddr, uhost_resp_srcaddr};

    // Test sequencer: state, word index, pattern and all registered outputs
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state       <= S_IDLE;
            r_seed        <= '0;
            r_nwords      <= '0;
            r_k           <= '0;
            r_pat         <= '0;
            r_wait        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_err_count   <= '0;
            r_err_addr    <= '0;
            r_req_valid   <= 1'b0;
            r_req_cmd     <= '0;
            r_req_dstaddr <= '0;
            r_req_srcaddr <= '0;
            r_req_data    <= '0;
            r_resp_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_seed      <= seed;
                        r_nwords    <= nwords;
                        r_k         <= '0;
                        r_pat       <= seed;
                        r_err_count <= '0;
                        r_err_addr  <= '0;
                        r_timeout   <= 1'b0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        if (nwords == 16'd0) begin
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_busy        <= 1'b1;
                            r_req_valid   <= 1'b1;
                            r_req_cmd     <= CMD_WRITE;
                            r_req_dstaddr <= BASEADDR;
                            r_req_srcaddr <= SRCADDR;
                            r_req_data    <= {NLANE{seed}};
                            r_state       <= S_WREQ;
                        end
                    end
                end

                S_WREQ: begin
                    if (w_req_hs) begin
                        r_req_valid  <= 1'b0;
                        r_resp_ready <= 1'b1;
                        r_wait       <= '0;
                        r_state      <= S_WRESP;
                    end
                end

                S_WRESP: begin
                    if (w_resp_hs) begin
                        r_err_count   <= w_err_count_nxt;
                        r_resp_ready  <= 1'b0;
                        r_req_valid   <= 1'b1;
                        r_req_srcaddr <= SRCADDR;
                        if (w_last) begin
                            r_k           <= '0;
                            r_pat         <= r_seed;
                            r_req_cmd     <= CMD_READ;
                            r_req_dstaddr <= BASEADDR;
                            r_req_data    <= '0;
                            r_state       <= S_RREQ;
                        end else begin
                            r_k           <= r_k + 16'd1;
                            r_pat         <= w_pat_nxt;
                            r_req_cmd     <= CMD_WRITE;
                            r_req_dstaddr <= w_addr_nxt;
                            r_req_data    <= {NLANE{w_pat_nxt}};
                            r_state       <= S_WREQ;
                        end
                    end else if (w_wait_exp) begin
                        r_timeout    <= 1'b1;
                        r_resp_ready <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_state      <= S_DONE;
                    end else begin
                        r_wait <= r_wait + TW'(1);
                    end
                end

                S_RREQ: begin
                    if (w_req_hs) begin
                        r_req_valid  <= 1'b0;
                        r_resp_ready <= 1'b1;
                        r_wait       <= '0;
                        r_state      <= S_RRESP;
                    end
                end

                S_RRESP: begin
                    if (w_resp_hs) begin
                        r_err_count  <= w_err_count_nxt;
                        r_resp_ready <= 1'b0;
                        if (w_err_inc && (r_err_count == 16'd0)) begin
                            r_err_addr <= r_req_dstaddr;
                        end
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_count_nxt == 16'd0);
                            r_state <= S_DONE;
                        end else begin
                            r_k           <= r_k + 16'd1;
                            r_pat         <= w_pat_nxt;
                            r_req_valid   <= 1'b1;
                            r_req_cmd     <= CMD_READ;
                            r_req_dstaddr <= w_addr_nxt;
                            r_req_srcaddr <= SRCADDR;
                            r_req_data    <= '0;
                            r_state       <= S_RREQ;
                        end
                    end else if (w_wait_exp) begin
                        r_timeout    <= 1'b1;
                        r_resp_ready <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_state      <= S_DONE;
                    end else begin
                        r_wait <= r_wait + TW'(1);
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign pass              = r_pass;
    assign timeout           = r_timeout;
    assign err_count         = r_err_count;
    assign err_addr          = r_err_addr;
    assign uhost_req_valid   = r_req_valid;
    assign uhost_req_cmd     = r_req_cmd;
    assign uhost_req_dstaddr = r_req_dstaddr;
    assign uhost_req_srcaddr = r_req_srcaddr;
    assign uhost_req_data    = r_req_data;
    assign uhost_resp_ready  = r_resp_ready;

endmodule

// File: tb/tb_umi_mem_checker.sv
// Directed bench for umi_mem_checker: a umi_ram-like responder, a transaction-level
// model of the expected request stream and final results, and per-cycle rule checks.
module tb_umi_mem_checker;

    localparam int unsigned CW  = 32;
    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 256;
    localparam int unsigned NL  = DW / 32;
    localparam int unsigned TMO = 16;
    localparam logic [AW-1:0] SRC = 64'h0000_00A5_0000_0100;

    // size field = log2(32 bytes) = 5 -> 5<<5 = 0xA0
    localparam logic [CW-1:0] CMD_W  = 32'h0000_00A3;
    localparam logic [CW-1:0] CMD_R  = 32'h0000_00A1;
    localparam logic [CW-1:0] RESP_W = 32'h0000_00A4;
    localparam logic [CW-1:0] RESP_R = 32'h0000_00A2;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   seed = '0;
    logic [15:0]   nwords = '0;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] err_addr;
    logic          uhost_req_valid;
    logic [CW-1:0] uhost_req_cmd;
    logic [AW-1:0] uhost_req_dstaddr;
    logic [AW-1:0] uhost_req_srcaddr;
    logic [DW-1:0] uhost_req_data;
    logic          uhost_req_ready = 1'b0;
    logic          uhost_resp_valid = 1'b0;
    logic [CW-1:0] uhost_resp_cmd = '0;
    logic [AW-1:0] uhost_resp_dstaddr = '0;
    logic [AW-1:0] uhost_resp_srcaddr = '0;
    logic [DW-1:0] uhost_resp_data = '0;
    logic          uhost_resp_ready;

    umi_mem_checker #(
        .CW(CW), .AW(AW), .DW(DW), .BASEADDR(64'h0), .SRCADDR(SRC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .nreset(nreset), .start(start), .seed(seed), .nwords(nwords),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .err_addr(err_addr),
        .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
        .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
        .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
        .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
        .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
        .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    int            n_chk = 0;
    int            n_err = 0;
    int            n_req = 0;
    int            mode = 0;          // 0 zero-wait, 1 random stalls, 2 never respond
    int            corrupt_word = -1;
    req_t          exp_q[$];
    logic [AW-1:0] obs_waddr[$];
    logic [DW-1:0] obs_wdata[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] rep(input logic [31:0] w);
        return {NL{w}};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected request stream: nwords writes of seed+k, then nwords reads, word stride 32 bytes
    task automatic setup(input logic [31:0] s, input logic [15:0] n, input int md, input int cw);
        mode = md;
        corrupt_word = cw;
        mem.delete();
        exp_q.delete();
        obs_waddr.delete();
        obs_wdata.delete();
        n_req = 0;
        for (int k = 0; k < int'(n); k++)
            exp_q.push_back('{CMD_W, AW'(k * 32), rep(s + 32'(k))});
        for (int k = 0; k < int'(n); k++)
            exp_q.push_back('{CMD_R, AW'(k * 32), '0});
        seed = s;
        nwords = n;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_err_addr"}, err_addr, 0);
        chk({tag, "_req_valid"}, uhost_req_valid, 0);
        chk({tag, "_req_cmd"}, uhost_req_cmd, 0);
        chk({tag, "_req_dst"}, uhost_req_dstaddr, 0);
        chk({tag, "_req_src"}, uhost_req_srcaddr, 0);
        chk({tag, "_req_data"}, uhost_req_data, 0);
        chk({tag, "_resp_ready"}, uhost_resp_ready, 0);
    endtask

    task automatic run_test(input string tag, input logic [31:0] s, input logic [15:0] n,
                            input int md, input int cw, input int repulse, input int exp_cyc);
        int cyc;
        int limit;
        int exp_err;
        int exp_nreq;
        bit exp_to;
        logic [AW-1:0] exp_eaddr;
        setup(s, n, md, cw);
        exp_err   = (md != 2 && cw >= 0 && cw < int'(n)) ? 1 : 0;
        exp_eaddr = (exp_err != 0) ? AW'(cw * 32) : '0;
        exp_to    = (md == 2 && n != 0);
        exp_nreq  = (md == 2) ? ((n != 0) ? 1 : 0) : 2 * int'(n);
        limit     = 64 * int'(n) + 200;
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (cyc == repulse) begin
                start  = 1'b1;
                seed   = ~s;
                nwords = n + 16'd5;
            end
        end while (!done && cyc < limit);
        chk({tag, "_done_seen"}, done, 1);
        if (exp_cyc > 0) chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pass"}, pass, (exp_err == 0 && !exp_to) ? 1 : 0);
        chk({tag, "_timeout"}, timeout, exp_to);
        chk({tag, "_err_count"}, err_count, exp_err);
        chk({tag, "_err_addr"}, err_addr, exp_eaddr);
        chk({tag, "_req_count"}, n_req, exp_nreq);
        if (md != 2) chk({tag, "_all_reqs_seen"}, exp_q.size(), 0);
        @(posedge clk); #1;
        chk({tag, "_done_held"}, done, 1);
        chk({tag, "_pass_held"}, pass, (exp_err == 0 && !exp_to) ? 1 : 0);
        chk({tag, "_err_held"}, err_count, exp_err);
    endtask

    // Responder (umi_ram-like) plus request-stream and per-cycle protocol checks
    initial begin : responder
        bit            pend;
        int            dly;
        bit            held;
        logic [CW-1:0] rcmd;
        logic [DW-1:0] rdata;
        req_t          prev;
        req_t          e;
        pend = 0; dly = 0; held = 0; rcmd = '0; rdata = '0;
        prev = '{'0, '0, '0};
        forever begin
            @(negedge clk);
            if (!nreset) begin
                pend = 0;
                held = 0;
                uhost_req_ready  = 1'b0;
                uhost_resp_valid = 1'b0;
                uhost_resp_cmd   = '0;
                uhost_resp_data  = '0;
                continue;
            end
            chk("req_resp_overlap", uhost_req_valid && uhost_resp_ready, 0);
            if (!busy) chk("req_valid_while_idle", uhost_req_valid, 0);
            if (held) begin
                chk("req_hold_valid", uhost_req_valid, 1);
                chk("req_hold_fields", {uhost_req_cmd, uhost_req_dstaddr, uhost_req_data},
                    {prev.cmd, prev.addr, prev.data});
            end
            uhost_resp_valid = 1'b0;
            if (pend) begin
                if (dly > 0) begin
                    dly--;
                end else begin
                    uhost_resp_valid = 1'b1;
                    uhost_resp_cmd   = rcmd;
                    uhost_resp_data  = rdata;
                    if (uhost_resp_ready) pend = 0;
                end
            end
            held = 0;
            uhost_req_ready = 1'b0;
            if (uhost_req_valid) begin
                uhost_req_ready = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (uhost_req_ready) begin
                    n_req++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_req: got cmd %0h addr %0h expected none",
                                 uhost_req_cmd, uhost_req_dstaddr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_cmd", uhost_req_cmd, e.cmd);
                        chk("req_addr", uhost_req_dstaddr, e.addr);
                        chk("req_data", uhost_req_data, e.data);
                        chk("req_src", uhost_req_srcaddr, SRC);
                    end
                    if (uhost_req_cmd[4:0] == 5'h03) begin
                        obs_waddr.push_back(uhost_req_dstaddr);
                        obs_wdata.push_back(uhost_req_data);
                        mem[uhost_req_dstaddr] = uhost_req_data;
                        rcmd  = RESP_W;
                        rdata = '0;
                    end else begin
                        rdata = mem.exists(uhost_req_dstaddr) ? mem[uhost_req_dstaddr] : '0;
                        if (corrupt_word >= 0 && uhost_req_dstaddr == AW'(corrupt_word * 32))
                            rdata[0] = ~rdata[0];
                        rcmd = RESP_R;
                    end
                    if (mode != 2) begin
                        pend = 1;
                        dly  = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
                    end
                end else begin
                    held = 1;
                    prev = '{uhost_req_cmd, uhost_req_dstaddr, uhost_req_data};
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin : main
        int  cyc;
        bit  found;
        logic [DW-1:0] tmp;

        repeat (3) begin @(posedge clk); #1; end
        check_all_zero("reset");
        nreset = 1'b1;
        @(posedge clk); #1;

        // basic: 4 words, zero-wait; 4*4+1 cycles start->done
        run_test("basic", 32'h0000_1000, 16'd4, 0, -1, -1, 17);
        chk("basic_nwrites", obs_waddr.size(), 4);
        chk("basic_waddr1", obs_waddr[1], 64'd32);
        chk("basic_waddr3", obs_waddr[3], 64'd96);
        tmp = {8{32'h0000_1002}};
        chk("basic_wdata2", obs_wdata[2], tmp);

        // read data of word 2 corrupted
        run_test("corrupt", 32'h0, 16'd8, 0, 2, -1, 33);
        chk("corrupt_err_addr_lit", err_addr, 64'd64);
        chk("corrupt_err_count_lit", err_count, 16'd1);
        chk("corrupt_pass_lit", pass, 0);

        // random request/response stalls
        run_test("stall", 32'hCAFE_0000, 16'd16, 1, -1, -1, -1);

        // first write never answered: 1 cycle WREQ + handshake + 16 waiting cycles
        run_test("timeout", 32'h0000_0055, 16'd4, 2, -1, -1, 18);
        chk("timeout_lit", timeout, 1);
        chk("timeout_one_req", n_req, 1);

        // zero words: done the cycle after start, nothing issued
        run_test("zero", 32'h1234_5678, 16'd0, 0, -1, -1, 1);

        // second start while busy must not disturb the run
        run_test("ignore_start", 32'h0000_0200, 16'd3, 0, -1, 3, 13);

        // reset while the first read is pending
        setup(32'h0000_0300, 16'd4, 0, -1);
        start = 1'b1;
        cyc = 0;
        found = 0;
        while (!found && cyc < 200) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (uhost_req_valid && uhost_req_cmd[4:0] == 5'h01) found = 1;
        end
        chk("rst_reach_rreq", found, 1);
        nreset = 1'b0;
        @(posedge clk); #1;
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        nreset = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("rst_no_req", uhost_req_valid, 0);
        end
        chk("rst_req_count", n_req, 4);
        chk("rst_no_done", done, 0);

        // restart after abort; pattern wraps to 0 on word 1
        run_test("wrap", 32'hFFFF_FFFF, 16'd2, 0, -1, -1, 9);
        tmp = {8{32'hFFFF_FFFF}};
        chk("wrap_wdata0", obs_wdata[0], tmp);
        tmp = '0;
        chk("wrap_wdata1", obs_wdata[1], tmp);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
